// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the boot-time instruction loader.
//   state_t        - loader FSM states (LOAD, HOLD, RUN, ERROR)
//   BYTES_PER_WORD - bytes packed into each 32-bit instruction word
//   LANE_W         - width of the byte-lane index inside a word
package loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    LOAD,
    HOLD,
    RUN,
    ERROR
  } state_t;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// byte_packer: assembles a little-endian byte stream into 32-bit words.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (clears byte counter)
//   accept      - a byte handshake happens this cycle
//   data, last  - byte payload and end-of-image marker for the accepted byte
//   word_valid  - this handshake completes a word (combinational pulse)
//   word_last   - the completing byte carries last
//   short_last  - last arrived on lane 0..2 (partial final word)
//   word        - assembled word, valid alongside word_valid
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [7:0]  data,
  input  logic        last,
  output logic        word_valid,
  output logic        word_last,
  output logic        short_last,
  output logic [31:0] word
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] byte_cnt;
  // Lower three lanes, shifted in from the top so byte 0 settles in [7:0].
  logic [23:0]       partial;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      partial  <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 1'b1;
      if (byte_cnt != LAST_LANE) begin
        partial <= {data, partial[23:8]};
      end
    end
  end

  // The fourth byte is merged directly so the FSM can register the write on
  // the same edge as the completing handshake.
  always_comb begin
    word_valid = accept && (byte_cnt == LAST_LANE);
    word_last  = word_valid && last;
    short_last = accept && last && (byte_cnt != LAST_LANE);
    word       = {data, partial};
  end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: boot-time loader that streams a byte image into the core's
// instruction memory, holds the core in reset while loading, then releases it.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   s_valid/s_data/s_last/s_ready - byte stream handshake
//   imem_we/imem_addr/imem_wdata  - single-cycle instruction-memory write
//   cpu_rstn            - active-low reset to the core
//   done                - image loaded and core released
//   err                 - sticky load error (short final word, overflow, bad checksum)
// Build option: LOADER_CHECKSUM_EN - final word is a mod-2^32 checksum of the
//   preceding words; it is compared, never written.
module inst_loader
  import loader_pkg::*;
#(
  parameter int unsigned NUM_INSTS   = 512,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              err
);

  localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]   FULL      = (ADDR_W + 1)'(NUM_INSTS);

  state_t            state;
  logic [ADDR_W:0]   word_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept;
  logic              word_valid;
  logic              word_last;
  logic              short_last;
  logic [31:0]       word;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       sum;
`endif

  always_comb begin
    s_ready = (state == LOAD);
    accept  = s_valid && s_ready;
  end

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .data       (s_data),
    .last       (s_last),
    .word_valid (word_valid),
    .word_last  (word_last),
    .short_last (short_last),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      word_cnt   <= '0;
      hold_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rstn   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        LOAD: begin
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            // Checksum word is exempt from capacity, so a full memory still
            // accepts bytes; only a further non-final word overflows.
            if (short_last) begin
              state <= ERROR;
              err   <= 1'b1;
            end else if (word_last) begin
              if (word == sum) begin
                state    <= HOLD;
                hold_cnt <= '0;
              end else begin
                state <= ERROR;
                err   <= 1'b1;
              end
            end else if (word_valid) begin
              if (word_cnt == FULL) begin
                state <= ERROR;
                err   <= 1'b1;
              end else begin
                imem_we    <= 1'b1;
                imem_addr  <= word_cnt[ADDR_W-1:0];
                imem_wdata <= word;
                sum        <= sum + word;
                word_cnt   <= word_cnt + 1'b1;
              end
            end
`else
            if (word_cnt == FULL || short_last) begin
              state <= ERROR;
              err   <= 1'b1;
            end else if (word_valid) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[ADDR_W-1:0];
              imem_wdata <= word;
              if (word_last) begin
                state    <= HOLD;
                hold_cnt <= '0;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
`endif
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= RUN;
            cpu_rstn <= 1'b1;
            done     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
        end
        ERROR: begin
        end
        default: begin
          state <= ERROR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule
